// File: rtl/imem_program_loader_if.sv
// Host handshake, IMEM write port and loader status signals.
// The loader itself uses the slave modport. The host or bench uses the master modport.
interface imem_program_loader_if;
  logic        START;
  logic        ABORT;
  logic [5:0]  WORD_COUNT;
  logic [15:0] DATA_IN;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic [3:0]  IMEM_WRITE_SELECT;
  logic        IMEM_LOW_WRITE_ENABLE;
  logic        IMEM_HIGH_WRITE_ENABLE;
  logic [15:0] IMEM_INPUT;
  logic        CPU_HALT;
  logic        LOAD_DONE;
  logic        LOAD_ERROR;
  logic [15:0] CHECKSUM;

  modport master (
    output START, ABORT, WORD_COUNT, DATA_IN, DATA_VALID,
    input  DATA_READY, IMEM_WRITE_SELECT, IMEM_LOW_WRITE_ENABLE, IMEM_HIGH_WRITE_ENABLE,
    input  IMEM_INPUT, CPU_HALT, LOAD_DONE, LOAD_ERROR, CHECKSUM
  );

  modport slave (
    input  START, ABORT, WORD_COUNT, DATA_IN, DATA_VALID,
    output DATA_READY, IMEM_WRITE_SELECT, IMEM_LOW_WRITE_ENABLE, IMEM_HIGH_WRITE_ENABLE,
    output IMEM_INPUT, CPU_HALT, LOAD_DONE, LOAD_ERROR, CHECKSUM
  );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction memory program loader.
// Accepts host words over valid/ready and turns each accepted word into a one-cycle write
// into the low bank (words 0-15) or the high bank (words 16-31).
// The CPU is held halted while a load is in progress. All outputs are registered.
// MAX_WORDS must be 16 (low bank only) or 32.
module imem_program_loader #(
  parameter int unsigned MAX_WORDS     = 32,
  parameter bit          HALT_ON_RESET = 1'b0
) (
  input logic                  CLOCK,
  input logic                  RESET,
  imem_program_loader_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush} state_e;

  localparam logic [6:0] MaxWords   = 7'(MAX_WORDS);
  // The high bank only exists in the 32-word configuration.
  localparam bit         HighBankEn = (MAX_WORDS > 16);

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        lo_we_q, lo_we_d;
  logic        hi_we_q, hi_we_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] wdata_q, wdata_d;
  logic        halt_q, halt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] csum_q, csum_d;
  logic [4:0]  addr_q, addr_d;
  logic [5:0]  remain_q, remain_d;

  logic start_ok;
  logic accept;

  // Next-state and registered-output computation for the load sequencer.
  always_comb begin
    start_ok = ({1'b0, bus_io.WORD_COUNT} != 7'd0) && ({1'b0, bus_io.WORD_COUNT} <= MaxWords);
    accept   = bus_io.DATA_VALID & ready_q;

    state_d  = state_q;
    ready_d  = ready_q;
    lo_we_d  = 1'b0;
    hi_we_d  = 1'b0;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    halt_d   = halt_q;
    done_d   = 1'b0;
    err_d    = err_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    remain_d = remain_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.START) begin
          if (start_ok) begin
            state_d  = StLoad;
            ready_d  = 1'b1;
            remain_d = bus_io.WORD_COUNT;
            addr_d   = 5'd0;
            csum_d   = 16'd0;
            err_d    = 1'b0;
            halt_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // Abort wins over a same-cycle accept; that word is neither written nor summed.
        if (bus_io.ABORT) begin
          state_d = StIdle;
          ready_d = 1'b0;
          err_d   = 1'b1;
        end else if (accept) begin
          wdata_d  = bus_io.DATA_IN;
          sel_d    = addr_q[3:0];
          lo_we_d  = ~addr_q[4];
          hi_we_d  = addr_q[4] & HighBankEn;
          addr_d   = addr_q + 5'd1;
          csum_d   = csum_q + bus_io.DATA_IN;
          remain_d = remain_q - 6'd1;
          if (remain_q == 6'd1) begin
            state_d = StFlush;
            ready_d = 1'b0;
          end
        end
      end
      StFlush: begin
        // The final write is on the bus this cycle. Release the CPU as we return to idle.
        state_d = StIdle;
        done_d  = 1'b1;
        halt_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= StIdle;
      ready_q  <= 1'b0;
      lo_we_q  <= 1'b0;
      hi_we_q  <= 1'b0;
      sel_q    <= 4'd0;
      wdata_q  <= 16'd0;
      halt_q   <= HALT_ON_RESET;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      csum_q   <= 16'd0;
      addr_q   <= 5'd0;
      remain_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      lo_we_q  <= lo_we_d;
      hi_we_q  <= hi_we_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      halt_q   <= halt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      csum_q   <= csum_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign bus_io.DATA_READY             = ready_q;
  assign bus_io.IMEM_WRITE_SELECT      = sel_q;
  assign bus_io.IMEM_LOW_WRITE_ENABLE  = lo_we_q;
  assign bus_io.IMEM_HIGH_WRITE_ENABLE = hi_we_q;
  assign bus_io.IMEM_INPUT             = wdata_q;
  assign bus_io.CPU_HALT               = halt_q;
  assign bus_io.LOAD_DONE              = done_q;
  assign bus_io.LOAD_ERROR             = err_q;
  assign bus_io.CHECKSUM               = csum_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed testbench for imem_program_loader.
// Inputs change 1 ns after each rising edge.
// Outputs are sampled at that same point, so they reflect the edge that just occurred.
module tb_imem_program_loader;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  imem_program_loader_if bus ();

  imem_program_loader #(
    .MAX_WORDS    (32),
    .HALT_ON_RESET(1'b0)
  ) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  // Every output, packed, for reset-value checks.
  logic [41:0] all_out;
  assign all_out = {bus.DATA_READY, bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE,
                    bus.IMEM_WRITE_SELECT, bus.IMEM_INPUT, bus.CPU_HALT, bus.LOAD_DONE,
                    bus.LOAD_ERROR, bus.CHECKSUM};

  // Write-port view: {low_we, high_we, sel, data}.
  logic [21:0] wr;
  assign wr = {bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE, bus.IMEM_WRITE_SELECT,
               bus.IMEM_INPUT};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.START      = 1'b0;
    bus.ABORT      = 1'b0;
    bus.WORD_COUNT = 6'd0;
    bus.DATA_IN    = 16'd0;
    bus.DATA_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    checks++;
    if (all_out !== 42'd0) begin
      errors++;
      $display("FAIL reset_in: outputs=%h want 0", all_out);
    end
    rst = 1'b0;
    step();
    checks++;
    if (all_out !== 42'd0) begin
      errors++;
      $display("FAIL reset_after: outputs=%h want 0", all_out);
    end
  endtask

  task automatic test_basic();
    logic [15:0] w;
    bus.START      = 1'b1;
    bus.WORD_COUNT = 6'd3;
    step();
    bus.START = 1'b0;
    checks++;
    if ({bus.DATA_READY, bus.CPU_HALT} !== 2'b11) begin
      errors++;
      $display("FAIL basic_enter: ready,halt=%b want 11", {bus.DATA_READY, bus.CPU_HALT});
    end
    for (int i = 0; i < 3; i++) begin
      w              = 16'h1111 * 16'(i + 1);
      bus.DATA_VALID = 1'b1;
      bus.DATA_IN    = w;
      step();
      checks++;
      if (wr !== {2'b10, 4'(i), w}) begin
        errors++;
        $display("FAIL basic_write%0d: got %h want %h", i, wr, {2'b10, 4'(i), w});
      end
      checks++;
      if (bus.DATA_READY !== (i < 2)) begin
        errors++;
        $display("FAIL basic_ready%0d: got %b want %b", i, bus.DATA_READY, (i < 2));
      end
    end
    bus.DATA_VALID = 1'b0;
    step();
    checks++;
    if ({bus.LOAD_DONE, bus.CPU_HALT, bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE}
        !== 4'b1000) begin
      errors++;
      $display("FAIL basic_done: done,halt,lo,hi=%b want 1000",
               {bus.LOAD_DONE, bus.CPU_HALT, bus.IMEM_LOW_WRITE_ENABLE,
                bus.IMEM_HIGH_WRITE_ENABLE});
    end
    checks++;
    if (bus.CHECKSUM !== 16'h6666) begin
      errors++;
      $display("FAIL basic_csum: got %h want 6666", bus.CHECKSUM);
    end
    step();
    checks++;
    if ({bus.LOAD_DONE, bus.CHECKSUM} !== {1'b0, 16'h6666}) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b csum=%h want 0 6666", bus.LOAD_DONE, bus.CHECKSUM);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    bus.START      = 1'b1;
    bus.WORD_COUNT = 6'd32;
    step();
    bus.START      = 1'b0;
    bus.DATA_VALID = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.DATA_IN = 16'(i);
      step();
      exp = {(i < 16), (i >= 16), 4'(i), 16'(i)};
      checks++;
      if (wr !== exp) begin
        errors++;
        $display("FAIL full_write%0d: got %h want %h", i, wr, exp);
      end
    end
    bus.DATA_VALID = 1'b0;
    checks++;
    if (bus.DATA_READY !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_drop: got %b want 0", bus.DATA_READY);
    end
    step();
    checks++;
    if ({bus.LOAD_DONE, bus.CPU_HALT, bus.CHECKSUM} !== {2'b10, 16'h01F0}) begin
      errors++;
      $display("FAIL full_done: done=%b halt=%b csum=%h want 1 0 01f0",
               bus.LOAD_DONE, bus.CPU_HALT, bus.CHECKSUM);
    end
    step();
  endtask

  task automatic test_gapped();
    bus.START      = 1'b1;
    bus.WORD_COUNT = 6'd2;
    step();
    bus.START      = 1'b0;
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 16'hABCD;
    step();
    checks++;
    if (wr !== {2'b10, 4'd0, 16'hABCD}) begin
      errors++;
      $display("FAIL gap_write0: got %h want %h", wr, {2'b10, 4'd0, 16'hABCD});
    end
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.DATA_READY, bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE} !== 3'b100) begin
        errors++;
        $display("FAIL gap_idle%0d: ready,lo,hi=%b want 100", i,
                 {bus.DATA_READY, bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE});
      end
    end
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 16'h1234;
    step();
    bus.DATA_VALID = 1'b0;
    checks++;
    if ({bus.DATA_READY, wr} !== {1'b0, 2'b10, 4'd1, 16'h1234}) begin
      errors++;
      $display("FAIL gap_write1: ready=%b wr=%h want 0 %h", bus.DATA_READY, wr,
               {2'b10, 4'd1, 16'h1234});
    end
    step();
    checks++;
    if ({bus.LOAD_DONE, bus.IMEM_LOW_WRITE_ENABLE, bus.CHECKSUM} !== {2'b10, 16'hBE01}) begin
      errors++;
      $display("FAIL gap_done: done=%b lo=%b csum=%h want 1 0 be01",
               bus.LOAD_DONE, bus.IMEM_LOW_WRITE_ENABLE, bus.CHECKSUM);
    end
    step();
  endtask

  task automatic test_illegal_count();
    logic [5:0] bad [2];
    bad[0] = 6'd0;
    bad[1] = 6'd33;
    for (int i = 0; i < 2; i++) begin
      bus.START      = 1'b1;
      bus.WORD_COUNT = bad[i];
      step();
      checks++;
      if ({bus.LOAD_ERROR, bus.DATA_READY, bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE,
           bus.CPU_HALT} !== 5'b10000) begin
        errors++;
        $display("FAIL illegal_%0d: err,ready,lo,hi,halt=%b want 10000", bad[i],
                 {bus.LOAD_ERROR, bus.DATA_READY, bus.IMEM_LOW_WRITE_ENABLE,
                  bus.IMEM_HIGH_WRITE_ENABLE, bus.CPU_HALT});
      end
    end
    bus.WORD_COUNT = 6'd1;
    step();
    bus.START = 1'b0;
    checks++;
    if ({bus.LOAD_ERROR, bus.DATA_READY, bus.CPU_HALT, bus.CHECKSUM} !== {3'b011, 16'h0}) begin
      errors++;
      $display("FAIL illegal_recover: err=%b ready=%b halt=%b csum=%h want 0 1 1 0000",
               bus.LOAD_ERROR, bus.DATA_READY, bus.CPU_HALT, bus.CHECKSUM);
    end
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 16'h0005;
    step();
    bus.DATA_VALID = 1'b0;
    checks++;
    if (wr !== {2'b10, 4'd0, 16'h0005}) begin
      errors++;
      $display("FAIL single_write: got %h want %h", wr, {2'b10, 4'd0, 16'h0005});
    end
    step();
    checks++;
    if ({bus.LOAD_DONE, bus.CPU_HALT} !== 2'b10) begin
      errors++;
      $display("FAIL single_done: done,halt=%b want 10", {bus.LOAD_DONE, bus.CPU_HALT});
    end
    step();
  endtask

  task automatic test_abort();
    bus.START      = 1'b1;
    bus.WORD_COUNT = 6'd4;
    step();
    bus.START      = 1'b0;
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 16'h0AAA;
    step();
    checks++;
    if (wr !== {2'b10, 4'd0, 16'h0AAA}) begin
      errors++;
      $display("FAIL abort_write0: got %h want %h", wr, {2'b10, 4'd0, 16'h0AAA});
    end
    bus.DATA_IN = 16'h0BBB;
    bus.ABORT   = 1'b1;
    step();
    bus.ABORT      = 1'b0;
    bus.DATA_VALID = 1'b0;
    checks++;
    if ({bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE, bus.DATA_READY, bus.LOAD_ERROR,
         bus.CPU_HALT} !== 5'b00011) begin
      errors++;
      $display("FAIL abort_cut: lo,hi,ready,err,halt=%b want 00011",
               {bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE, bus.DATA_READY,
                bus.LOAD_ERROR, bus.CPU_HALT});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({bus.LOAD_DONE, bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE, bus.CPU_HALT,
           bus.CHECKSUM} !== {4'b0001, 16'h0AAA}) begin
        errors++;
        $display("FAIL abort_after%0d: done=%b lo=%b hi=%b halt=%b csum=%h want 0 0 0 1 0aaa",
                 i, bus.LOAD_DONE, bus.IMEM_LOW_WRITE_ENABLE, bus.IMEM_HIGH_WRITE_ENABLE,
                 bus.CPU_HALT, bus.CHECKSUM);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    bus.START      = 1'b1;
    bus.WORD_COUNT = 6'd4;
    step();
    // START held with a different count while loading must not retarget the load.
    bus.WORD_COUNT = 6'd1;
    bus.DATA_VALID = 1'b1;
    bus.DATA_IN    = 16'h0101;
    step();
    checks++;
    if ({bus.DATA_READY, wr} !== {1'b1, 2'b10, 4'd0, 16'h0101}) begin
      errors++;
      $display("FAIL ignore_start0: ready=%b wr=%h want 1 %h", bus.DATA_READY, wr,
               {2'b10, 4'd0, 16'h0101});
    end
    bus.DATA_IN = 16'h0202;
    step();
    checks++;
    if ({bus.DATA_READY, bus.LOAD_ERROR, wr} !== {2'b10, 2'b10, 4'd1, 16'h0202}) begin
      errors++;
      $display("FAIL ignore_start1: ready=%b err=%b wr=%h want 1 0 %h", bus.DATA_READY,
               bus.LOAD_ERROR, wr, {2'b10, 4'd1, 16'h0202});
    end
    bus.START   = 1'b0;
    bus.DATA_IN = 16'h0303;
    rst         = 1'b1;
    step();
    checks++;
    if (all_out !== 42'd0) begin
      errors++;
      $display("FAIL mid_reset: outputs=%h want 0", all_out);
    end
    rst = 1'b0;
    step();
    checks++;
    if (all_out !== 42'd0) begin
      errors++;
      $display("FAIL mid_reset_after: outputs=%h want 0", all_out);
    end
    bus.DATA_VALID = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gapped();
    test_illegal_count();
    test_abort();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
